alu_seq_ctrl: RTL and testbench
===============================

# alu_seq_ctrl

Multi-cycle multiply/divide sequencer that computes MIPS `MULTU`/`DIVU` (and optionally `MULT`/`DIV`) results using the existing 32-bit ALU.
- Multiply uses shift-add; divide uses restoring division.
- The block drives the ALU's opcode and operands every cycle and consumes its result.
- It sits beside the execute stage, talks to the core through a start/busy/done handshake, and writes the HI/LO result pair.

## Interface
Parameters:
- `DIV0_QUOT`, default 32'hFFFF_FFFF: quotient (`lo`) returned on divide-by-zero.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: request pulse; sampled only when `busy`=0.
- `op`  in  2: bit0 0=multiply, 1=divide; bit1 1=signed (honoured only with macro).
- `a`  in  32: multiplicand / dividend.
- `b`  in  32: multiplier / divisor.
- `busy`  out  1: high whenever state≠IDLE.
- `done`  out  1: one-cycle pulse; `hi`/`lo` are valid from this cycle.
- `hi`  out  32: product[63:32] / remainder.
- `lo`  out  32: product[31:0] / quotient.
- `alu_op`  out  3: ALU opcode; 3'b010 add, 3'b110 subtract.
- `alu_a`  out  32: ALU operand A.
- `alu_b`  out  32: ALU operand B.
- `alu_y`  in  32: ALU result (combinational from `alu_op`/`alu_a`/`alu_b`).

## Operation
- States: IDLE, RUN, FIX (only with macro), DONE.
- **IDLE**
  - `start`=1: latch operands, clear the 5-bit counter, go to RUN.
  - Divide with `b`==0: go straight to DONE with `lo`=`DIV0_QUOT`, `hi`=`a`.
- **Multiply**
  - Working registers: `P_hi`=0, `P_lo`=multiplier, `M`=multiplicand.
  - Each RUN cycle drives `alu_op`=010, `alu_a`=`P_hi`, `alu_b`=`P_lo[0]` ? `M` : 0.
  - Carry c = (`alu_y` < `P_hi`), unsigned compare done locally.
  - Update {`P_hi`,`P_lo`} ← {c, `alu_y`, `P_lo[31:1]`}.
- **Divide**
  - Working registers: `R`=0, `Q`=dividend, `D`=divisor.
  - Each RUN cycle drives `alu_op`=110, `alu_a`={`R[30:0]`,`Q[31]`}, `alu_b`=`D`.
  - If `R[31]`=1 or `alu_a`≥`D`: `R`←`alu_y`, `Q`←{`Q[30:0]`,1}.
  - Otherwise: `R`←`alu_a`, `Q`←{`Q[30:0]`,0}.
- **RUN** lasts exactly 32 cycles (counter 0..31). After count 31, go to FIX if the op is signed and the macro is compiled in; otherwise go to DONE.
- **DONE**
  - Multiply result: `hi`←`P_hi`, `lo`←`P_lo`.
  - Divide result: `hi`←`R`, `lo`←`Q`.
  - `done`=1 for one cycle, then return to IDLE.
- `hi`/`lo` change only on entry to DONE and otherwise hold their last value. Working registers are never visible on `hi`/`lo`.
- Outside RUN, drive `alu_op`=3'b010, `alu_a`=0, `alu_b`=0.
- `start` while `busy`=1 is ignored, with no effect on the state or on the operation in flight.

## Timing
- Reset (async, any state, including mid-RUN): state=IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, `alu_op`=3'b010, `alu_a`=0, `alu_b`=0, all working registers 0. No partial result is ever published.
- Latency, counted as edges from the `start` sampling edge to `done` high:
  - Unsigned op: 33 cycles.
  - Signed op with macro: 34 cycles.
  - Divide-by-zero: 1 cycle.
- `busy` rises the cycle after `start` is accepted and falls the cycle after `done`.
- A new `start` is accepted at the earliest in the cycle after `done`, i.e. back-to-back ops have a 1-cycle IDLE gap.
- The ALU path is combinational within a cycle. The `alu_y` → working-register path is the critical path.

## Configuration
- `ALU_SEQ_SIGNED_EN`
  - **Defined**
    - `op[1]`=1 selects signed operation.
    - At `start`, `a` and `b` are replaced by their absolute values, using local negation (not the ALU).
    - FIX state (1 cycle) negates the product when the signs differ, negates the quotient when the signs differ, and gives the remainder the sign of the dividend.
    - Signed divide-by-zero: `lo`=`DIV0_QUOT`, `hi`=`a`.
    - Signed 0x80000000/0xFFFFFFFF: `lo`=0x80000000, `hi`=0.
  - **Undefined**
    - `op[1]` is ignored, all ops are unsigned, and the FIX state and its logic are absent.

## Test plan
- Multiply, `a`=`b`=0xFFFFFFFF → `done` exactly 33 cycles after `start`; `hi`=0xFFFFFFFE, `lo`=0x00000001; `busy` high for 33 cycles.
- Divide, `a`=100, `b`=7 → `lo`=14, `hi`=2. Divide, `a`=0xFFFFFFFF, `b`=1 → `lo`=0xFFFFFFFF, `hi`=0.
- Divide, `a`=0x12345678, `b`=0 → `done` 1 cycle after `start`; `lo`=0xFFFFFFFF, `hi`=0x12345678.
- Pulse `start` with new operands at RUN cycle 10 → ignored, and the first result is unchanged. Assert `rst` at RUN cycle 20 → all outputs 0, IDLE; the next op completes correctly.
- With `ALU_SEQ_SIGNED_EN`:
  - `op`=3, −7/2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - `op`=2, −3×5 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1, `done` at cycle 34.
- Without `ALU_SEQ_SIGNED_EN`: same stimulus → unsigned results, `done` at cycle 33.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle MULTU/DIVU sequencer (shift-add / restoring divide) that borrows the execute ALU.
// Define ALU_SEQ_SIGNED_EN to add signed MULT/DIV (op[1]) via operand abs + a FIX cycle.
module alu_seq_ctrl #(
    parameter logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    // Handshake: start is sampled only while busy=0. busy rises the cycle after
    // acceptance; done pulses for one cycle with hi/lo valid, busy drops after it.
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [2:0]  alu_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_y,
    output logic [1:0]  dbg_state
);

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
`ifdef ALU_SEQ_SIGNED_EN
        S_FIX  = 2'd2,
`endif
        S_DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        is_div_q, is_div_d;
    logic [31:0] w_hi_q, w_hi_d;   // P_hi / R
    logic [31:0] w_lo_q, w_lo_d;   // P_lo / Q
    logic [31:0] m_q, m_d;         // M / D
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] a_in, b_in, div_sh;
    logic        carry, sgn_start;

`ifdef ALU_SEQ_SIGNED_EN
    logic        sgn_q, sgn_d;
    logic        neg_lo_q, neg_lo_d;
    logic        neg_hi_q, neg_hi_d;
    logic [63:0] prod_fix;

    assign sgn_start = op[1];
    assign a_in      = (op[1] && a[31]) ? (32'd0 - a) : a;
    assign b_in      = (op[1] && b[31]) ? (32'd0 - b) : b;
`else
    // op[1] is a don't-care in the unsigned-only build.
    assign sgn_start = op[1] & 1'b0;
    assign a_in      = a;
    assign b_in      = b;
`endif

    assign div_sh = {w_hi_q[30:0], w_lo_q[31]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            w_hi_q   <= '0;
            w_lo_q   <= '0;
            m_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
`ifdef ALU_SEQ_SIGNED_EN
            sgn_q    <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            w_hi_q   <= w_hi_d;
            w_lo_q   <= w_lo_d;
            m_q      <= m_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
`ifdef ALU_SEQ_SIGNED_EN
            sgn_q    <= sgn_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        w_hi_d   = w_hi_q;
        w_lo_d   = w_lo_q;
        m_d      = m_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        alu_op   = ALU_ADD;
        alu_a    = '0;
        alu_b    = '0;
        carry    = 1'b0;
`ifdef ALU_SEQ_SIGNED_EN
        sgn_d    = sgn_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        prod_fix = '0;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d    = '0;
                    is_div_d = op[0] | sgn_start & 1'b0;
                    w_hi_d   = '0;
                    w_lo_d   = op[0] ? a_in : b_in;
                    m_d      = op[0] ? b_in : a_in;
`ifdef ALU_SEQ_SIGNED_EN
                    sgn_d    = op[1];
                    neg_lo_d = op[1] & (a[31] ^ b[31]);
                    neg_hi_d = op[1] & (op[0] ? a[31] : (a[31] ^ b[31]));
`endif
                    if (op[0] && b == 32'd0) begin
                        state_d = S_DONE;
                        hi_d    = a;
                        lo_d    = DIV0_QUOT;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + 5'd1;
                if (is_div_q) begin
                    alu_op = ALU_SUB;
                    alu_a  = div_sh;
                    alu_b  = m_q;
                    // R[31] set means the shifted remainder overflowed 32 bits, so it must exceed D.
                    if (w_hi_q[31] || div_sh >= m_q) begin
                        w_hi_d = alu_y;
                        w_lo_d = {w_lo_q[30:0], 1'b1};
                    end else begin
                        w_hi_d = div_sh;
                        w_lo_d = {w_lo_q[30:0], 1'b0};
                    end
                end else begin
                    alu_a  = w_hi_q;
                    alu_b  = w_lo_q[0] ? m_q : 32'd0;
                    carry  = (alu_y < w_hi_q);
                    w_hi_d = {carry, alu_y[31:1]};
                    w_lo_d = {alu_y[0], w_lo_q[31:1]};
                end
                if (cnt_q == 5'd31) begin
`ifdef ALU_SEQ_SIGNED_EN
                    if (sgn_q) begin
                        state_d = S_FIX;
                    end else begin
                        state_d = S_DONE;
                        hi_d    = w_hi_d;
                        lo_d    = w_lo_d;
                    end
`else
                    state_d = S_DONE;
                    hi_d    = w_hi_d;
                    lo_d    = w_lo_d;
`endif
                end
            end
`ifdef ALU_SEQ_SIGNED_EN
            S_FIX: begin
                state_d = S_DONE;
                if (is_div_q) begin
                    hi_d = neg_hi_q ? (32'd0 - w_hi_q) : w_hi_q;
                    lo_d = neg_lo_q ? (32'd0 - w_lo_q) : w_lo_q;
                end else begin
                    prod_fix = neg_lo_q ? (64'd0 - {w_hi_q, w_lo_q}) : {w_hi_q, w_lo_q};
                    hi_d     = prod_fix[63:32];
                    lo_d     = prod_fix[31:0];
                end
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: arithmetic/latency model, per-cycle compare, directed and random ops.
module tb_alu_seq_ctrl;

    localparam logic [31:0] TB_DIV0 = 32'hFFFF_FFFF;

    logic        clk, rst, start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] hi, lo;
    logic [2:0]  alu_op;
    logic [31:0] alu_a, alu_b, alu_y;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 0;

    alu_seq_ctrl #(.DIV0_QUOT(TB_DIV0)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
        .dbg_state(dbg_state)
    );

    // ALU seen by the sequencer
    assign alu_y = (alu_op == 3'b110) ? (alu_a - alu_b) : (alu_a + alu_b);

    // clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference arithmetic
    function automatic logic [63:0] model_res(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic   sgn;
        longint sx, sy, q, r, p;
        sgn = 1'b0;
`ifdef ALU_SEQ_SIGNED_EN
        sgn = o[1];
`endif
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (o[0]) begin
            if (y == 32'd0) return {x, TB_DIV0};
            if (sgn) begin
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            return {x % y, x / y};
        end
        if (sgn) begin
            p = sx * sy;
            return p;
        end
        return {32'd0, x} * {32'd0, y};
    endfunction

    function automatic int model_lat(input logic [1:0] o, input logic [31:0] y);
        if (o[0] && y == 32'd0) return 1;
`ifdef ALU_SEQ_SIGNED_EN
        if (o[1]) return 34;
`endif
        return 33;
    endfunction

    // cycle-level model: start acceptance, latency, result publication
    logic [63:0] exp_q[$];
    bit          m_busy, m_done, m_isdiv;
    int          m_left;
    logic [31:0] m_hi, m_lo;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy  <= 1'b0;
            m_done  <= 1'b0;
            m_isdiv <= 1'b0;
            m_left  <= 0;
            m_hi    <= '0;
            m_lo    <= '0;
            exp_q.delete();
        end else if (m_done) begin
            m_done <= 1'b0;
            m_busy <= 1'b0;
        end else if (m_busy) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_done <= 1'b1;
                m_hi   <= exp_q[0][63:32];
                m_lo   <= exp_q[0][31:0];
                exp_q.pop_front();
            end
        end else if (start) begin
            m_busy  <= 1'b1;
            m_isdiv <= op[0];
            m_left  <= model_lat(op, b) - 1;
            if (model_lat(op, b) == 1) begin
                m_done <= 1'b1;
                m_hi   <= model_res(op, a, b) >> 32;
                m_lo   <= model_res(op, a, b) & 64'hFFFF_FFFF;
            end else begin
                exp_q.push_back(model_res(op, a, b));
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            if (n_errors < 40) $display("FAIL %s: actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // per-cycle compare against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_busy", {31'd0, busy}, {31'd0, m_busy});
            chk("cyc_done", {31'd0, done}, {31'd0, m_done});
            chk("cyc_hi", hi, m_hi);
            chk("cyc_lo", lo, m_lo);
            if (!m_busy || m_done) begin
                chk("idle_alu_op", {29'd0, alu_op}, 32'd2);
                chk("idle_alu_a", alu_a, 32'd0);
                chk("idle_alu_b", alu_b, 32'd0);
            end else if (m_left >= 2) begin
                chk("run_alu_op", {29'd0, alu_op}, m_isdiv ? 32'd6 : 32'd2);
            end
        end
    end

    // drivers
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int poke_at, output int lat, output int bcnt);
        lat  = 1;
        bcnt = busy ? 1 : 0;
        while (!done && lat < 40) begin
            if (lat == poke_at) begin
                start = 1'b1;
                op    = 2'($urandom_range(0, 3));
                a     = $urandom;
                b     = $urandom;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
            if (busy) bcnt++;
        end
        start = 1'b0;
        chk("done_seen", {31'd0, done}, 32'd1);
    endtask

    task automatic run_chk(input string name, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] eh, input logic [31:0] el, input int elat, input int poke,
                           output int bcnt);
        int lat;
        issue(o, x, y);
        wait_done(poke, lat, bcnt);
        chk({name, "_lat"}, lat, elat);
        chk({name, "_hi"}, hi, eh);
        chk({name, "_lo"}, lo, el);
    endtask

    initial begin
        int bc, lat, sel;
        logic [1:0]  ro;
        logic [31:0] rx, ry;
        rst = 1'b1; start = 1'b0; op = 2'd0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        chk_en = 1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;

        run_chk("mul_ff", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33, 0, bc);
        chk("mul_ff_busy_cycles", bc, 33);
        run_chk("div_100_7", 2'b01, 32'd100, 32'd7, 32'd2, 32'd14, 33, 0, bc);
        run_chk("div_ff_1", 2'b01, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, 33, 0, bc);
        run_chk("div0", 2'b01, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF, 1, 0, bc);
        run_chk("mul_poke", 2'b00, 32'd1000, 32'd3000, 32'd0, 32'h002D_C6C0, 33, 10, bc);

        // asynchronous reset in the middle of RUN
        issue(2'b00, 32'hDEAD_BEEF, 32'h0123_4567);
        repeat (19) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_lo", lo, 32'd0);
        chk("midrst_alu_op", {29'd0, alu_op}, 32'd2);
        chk("midrst_alu_a", alu_a, 32'd0);
        chk("midrst_alu_b", alu_b, 32'd0);
        chk("midrst_state", {30'd0, dbg_state}, 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        run_chk("post_rst_div", 2'b01, 32'd100, 32'd7, 32'd2, 32'd14, 33, 0, bc);

`ifdef ALU_SEQ_SIGNED_EN
        run_chk("sdiv_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34, 0, bc);
        run_chk("smul_m3_5", 2'b10, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 34, 0, bc);
        run_chk("sdiv_min_m1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 34, 0, bc);
`else
        run_chk("sdiv_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'd1, 32'h7FFF_FFFC, 33, 0, bc);
        run_chk("smul_m3_5", 2'b10, 32'hFFFF_FFFD, 32'd5, 32'd4, 32'hFFFF_FFF1, 33, 0, bc);
        run_chk("sdiv_min_m1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 33, 0, bc);
`endif
        run_chk("sdiv0", 2'b11, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1, 0, bc);

        // random ops; per-cycle compare checks every result and handshake
        for (int i = 0; i < 250; i++) begin
            ro  = 2'($urandom_range(0, 3));
            sel = $urandom_range(0, 9);
            rx  = $urandom;
            ry  = $urandom;
            if (sel == 0) ry = 32'd0;
            else if (sel == 1) begin rx = 32'h8000_0000; ry = 32'hFFFF_FFFF; end
            else if (sel == 2) begin rx = $urandom_range(0, 20); ry = $urandom_range(0, 20); end
            else if (sel == 3) ry = $urandom_range(1, 9);
            issue(ro, rx, ry);
            wait_done(($urandom_range(0, 3) == 0) ? $urandom_range(1, 33) : 0, lat, bc);
            if ($urandom_range(0, 3) == 0) begin
                // start during the done cycle must be ignored
                start = 1'b1; op = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom;
            end
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                start = 1'b0;
            end
        end
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
